// File: rtl/sapu_pkg.sv
// Shared SAP-U definitions: default widths, loader state encoding and the
// parity helper used by the RAM (and by anything that needs to predict it).
package sapu_pkg;

  localparam int SAPU_DATA_W = 8;
  localparam int SAPU_ADDR_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } loader_state_e;

  // Even-parity bit of a word; narrower words are zero-extended by the caller,
  // which leaves the XOR reduction unchanged.
  function automatic logic even_par(input logic [63:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/sapu_ram_array.sv
// DEPTH-word storage, one synchronous write port, asynchronous read port.
// With SAPU_RAM_PARITY_EN a parity bit is stored per word and checked on read.
module sapu_ram_array
  import sapu_pkg::*;
#(
  parameter int DATA_W = SAPU_DATA_W,
  parameter int ADDR_W = SAPU_ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
`ifdef SAPU_RAM_PARITY_EN
  ,
  output logic              rd_par_err
`endif
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Data write; contents are intentionally never reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

`ifdef SAPU_RAM_PARITY_EN
  logic par_mem [DEPTH];

  // Parity bit is generated on every write, whatever the source.
  always_ff @(posedge clk) begin
    if (we) par_mem[waddr] <= even_par(64'(wdata));
  end

  assign rd_par_err = even_par(64'(mem[raddr])) ^ par_mem[raddr];
`endif

endmodule

// File: rtl/sapu_ram_loader.sv
// SAP-U main memory: RAM, MAR and sequential program loader.
// Optional feature macro: SAPU_RAM_PARITY_EN (adds stored parity + parity_err).
module sapu_ram_loader
  import sapu_pkg::*;
#(
  parameter int DATA_W = SAPU_DATA_W,
  parameter int ADDR_W = SAPU_ADDR_W
) (
  input  logic              clk,
  input  logic              clear_n,
  input  logic              prog_mode,
  input  logic [ADDR_W-1:0] prog_base,
  input  logic [DATA_W-1:0] prog_data,
  input  logic              prog_valid,
  output logic              prog_ready,
  output logic              prog_done,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              load_addr,
  input  logic              write_en,
  input  logic              output_enable,
  output logic [DATA_W-1:0] bus_out,
  output logic [ADDR_W-1:0] mar
`ifdef SAPU_RAM_PARITY_EN
  ,
  output logic              parity_err
`endif
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  loader_state_e     state, state_nxt;
  logic [ADDR_W-1:0] mar_nxt;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] rdata;

  // State and MAR register; clear_n wins over everything.
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state <= ST_IDLE;
      mar   <= '0;
    end else begin
      state <= state_nxt;
      mar   <= mar_nxt;
    end
  end

  // Next state, next MAR and the single write request (run or loader).
  // Writes always target the pre-edge MAR, so a combined load_addr+write_en
  // writes the old address.
  always_comb begin
    state_nxt = state;
    mar_nxt   = mar;
    mem_we    = 1'b0;
    mem_wdata = bus_in;
    unique case (state)
      ST_IDLE: begin
        if (prog_mode) begin
          mar_nxt   = prog_base;
          state_nxt = ST_LOAD;
        end else begin
          mem_we = write_en;
          if (load_addr) mar_nxt = bus_in[ADDR_W-1:0];
        end
      end
      ST_LOAD: begin
        if (!prog_mode) begin
          state_nxt = ST_IDLE;
        end else if (prog_valid) begin
          mem_we    = 1'b1;
          mem_wdata = prog_data;
          if (mar == LAST_ADDR) state_nxt = ST_DONE;
          else                  mar_nxt   = mar + 1'b1;
        end
      end
      ST_DONE: begin
        if (!prog_mode) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    // A beat presented while clear_n is low must not land in memory.
    if (!clear_n) mem_we = 1'b0;
  end

  // Moore handshake outputs and the gated read bus.
  always_comb begin
    prog_ready = (state == ST_LOAD);
    prog_done  = (state == ST_DONE);
    bus_out    = output_enable ? rdata : '0;
  end

`ifdef SAPU_RAM_PARITY_EN
  logic rd_par_err;
`endif

  sapu_ram_array #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk       (clk),
    .we        (mem_we),
    .waddr     (mar),
    .wdata     (mem_wdata),
    .raddr     (mar),
    .rdata     (rdata)
`ifdef SAPU_RAM_PARITY_EN
    ,
    .rd_par_err(rd_par_err)
`endif
  );

`ifdef SAPU_RAM_PARITY_EN
  // Registered parity check of the word being driven; quiet when not reading.
  always_ff @(posedge clk) begin
    if (!clear_n) parity_err <= 1'b0;
    else          parity_err <= output_enable & rd_par_err;
  end
`endif

endmodule

// File: tb/tb_sapu_ram_loader.sv
// Directed bench for sapu_ram_loader: run-mode access, loader streaming,
// backpressure/abort, reset during load, and parity when enabled.
module tb_sapu_ram_loader;
  import sapu_pkg::*;

  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          clear_n, prog_mode, prog_valid, load_addr, write_en, output_enable;
  logic [AW-1:0] prog_base;
  logic [DW-1:0] prog_data, bus_in;
  logic          prog_ready, prog_done;
  logic [DW-1:0] bus_out;
  logic [AW-1:0] mar;
`ifdef SAPU_RAM_PARITY_EN
  logic          parity_err;
`endif

  always #5 clk = ~clk;

  sapu_ram_loader #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk          (clk),
    .clear_n      (clear_n),
    .prog_mode    (prog_mode),
    .prog_base    (prog_base),
    .prog_data    (prog_data),
    .prog_valid   (prog_valid),
    .prog_ready   (prog_ready),
    .prog_done    (prog_done),
    .bus_in       (bus_in),
    .load_addr    (load_addr),
    .write_en     (write_en),
    .output_enable(output_enable),
    .bus_out      (bus_out),
    .mar          (mar)
`ifdef SAPU_RAM_PARITY_EN
    ,
    .parity_err   (parity_err)
`endif
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one edge and settle 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    load_addr = 1'b1; bus_in = DW'(a); step();
    load_addr = 1'b0; write_en = 1'b1; bus_in = d; step();
    write_en = 1'b0;
  endtask

  task automatic read_at(input logic [AW-1:0] a, output logic [DW-1:0] d);
    load_addr = 1'b1; bus_in = DW'(a); output_enable = 1'b1; step();
    load_addr = 1'b0;
    d = bus_out;
  endtask

  // Drain the scoreboard by reading every queued address back.
  task automatic drain(input string tag);
    exp_t e;
    logic [DW-1:0] d;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      read_at(e.addr, d);
      chk($sformatf("%s_mem%0h", tag, e.addr), 32'(d), 32'(e.data));
    end
    output_enable = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] d;
    clear_n = 1'b0; prog_mode = 1'b0; prog_valid = 1'b0; prog_base = '0;
    prog_data = '0; bus_in = '0; load_addr = 1'b0; write_en = 1'b0;
    output_enable = 1'b0;
    // Reset also holds with noisy run inputs: nothing may move.
    load_addr = 1'b1; bus_in = 8'h09;
    step(); step();
    chk("rst_mar", 32'(mar), 0);
    chk("rst_ready", 32'(prog_ready), 0);
    chk("rst_done", 32'(prog_done), 0);
    chk("rst_bus_oe0", 32'(bus_out), 0);
    load_addr = 1'b0; clear_n = 1'b1;

    // Known background for later "untouched" checks
    run_write(4'h7, 8'h5C);
    run_write(4'h2, 8'h3E);
    run_write(4'h5, 8'h55);

    // Basic run mode
    load_addr = 1'b1; bus_in = 8'h03; step();
    load_addr = 1'b0; write_en = 1'b1; bus_in = 8'hA5; step();
    write_en = 1'b0; output_enable = 1'b1; #1;
    chk("run_mar", 32'(mar), 3);
    chk("run_bus", 32'(bus_out), 32'hA5);
    output_enable = 1'b0; #1;
    chk("run_bus_oe0", 32'(bus_out), 0);

    // Simultaneous load_addr + write_en: write old MAR, then MAR moves
    load_addr = 1'b1; write_en = 1'b1; bus_in = 8'h07; step();
    load_addr = 1'b0; write_en = 1'b0; output_enable = 1'b1; #1;
    chk("sim_mar", 32'(mar), 7);
    chk("sim_mem7_kept", 32'(bus_out), 32'h5C);
    read_at(4'h3, d);
    chk("sim_mem3", 32'(d), 32'h07);
    // Upper bus bits discarded on address load
    read_at(4'h3, d);
    load_addr = 1'b1; bus_in = 8'hF3; step(); load_addr = 1'b0;
    chk("mar_trunc", 32'(mar), 3);
    output_enable = 1'b0;

    // Loader from 0xC, valid held high
    prog_base = 4'hC; prog_mode = 1'b1;
    chk("idle_ready0", 32'(prog_ready), 0);
    step();
    chk("load_ready", 32'(prog_ready), 1);
    chk("load_mar", 32'(mar), 32'hC);
    prog_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      prog_data = 8'(8'h11 * (i + 1));
      exp_q.push_back('{addr: AW'(12 + i), data: prog_data});
      if (i == 3) chk("done_before_last", 32'(prog_done), 0);
      step();
    end
    chk("done_rise", 32'(prog_done), 1);
    chk("done_ready0", 32'(prog_ready), 0);
    chk("done_mar", 32'(mar), 32'hF);
    prog_data = 8'hEE; step();  // stays DONE, no further write
    chk("done_hold", 32'(prog_done), 1);
    prog_valid = 1'b0; prog_mode = 1'b0; step();
    chk("done_fall", 32'(prog_done), 0);
    drain("ld");

    // Backpressure and abort after two beats
    prog_base = 4'h0; prog_mode = 1'b1; step();
    prog_valid = 1'b1; prog_data = 8'hA0; exp_q.push_back('{addr: 4'h0, data: 8'hA0}); step();
    prog_valid = 1'b0; prog_data = 8'hBB; step();
    chk("bp_mar_hold", 32'(mar), 1);
    prog_valid = 1'b1; prog_data = 8'hA1; exp_q.push_back('{addr: 4'h1, data: 8'hA1}); step();
    prog_data = 8'hA2; prog_mode = 1'b0; step();
    prog_valid = 1'b0;
    chk("abort_mar", 32'(mar), 2);
    chk("abort_ready", 32'(prog_ready), 0);
    chk("abort_done", 32'(prog_done), 0);
    exp_q.push_back('{addr: 4'h2, data: 8'h3E});
    drain("ab");

    // clear_n during LOAD at mar=5
    prog_base = 4'h0; prog_mode = 1'b1; step();
    prog_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      prog_data = 8'(8'hB0 + i);
      exp_q.push_back('{addr: AW'(i), data: prog_data});
      step();
    end
    chk("pre_clr_mar", 32'(mar), 5);
    prog_data = 8'hFF; clear_n = 1'b0; step();
    chk("clr_mar", 32'(mar), 0);
    chk("clr_ready", 32'(prog_ready), 0);
    chk("clr_done", 32'(prog_done), 0);
    prog_valid = 1'b0; prog_mode = 1'b0; clear_n = 1'b1; step();
    exp_q.push_back('{addr: 4'h5, data: 8'h55});
    drain("clr");

    // prog_base at the last address: exactly one word
    run_write(4'h0, 8'h01);
    prog_base = 4'hF; prog_mode = 1'b1; step();
    prog_valid = 1'b1; prog_data = 8'h99; step();
    chk("last_done", 32'(prog_done), 1);
    chk("last_mar", 32'(mar), 32'hF);
    prog_data = 8'h77; step();
    prog_valid = 1'b0; prog_mode = 1'b0; step();
    exp_q.push_back('{addr: 4'hF, data: 8'h99});
    exp_q.push_back('{addr: 4'h0, data: 8'h01});  // no wrap into address 0
    drain("last");

`ifdef SAPU_RAM_PARITY_EN
    run_write(4'h2, 8'h3C);
    load_addr = 1'b1; bus_in = 8'h02; output_enable = 1'b1; step();
    load_addr = 1'b0; step();
    chk("par_clean", 32'(parity_err), 0);
    dut.u_ram.mem[2] = 8'h3D;
    step();
    chk("par_err", 32'(parity_err), 1);
    output_enable = 1'b0; step();
    chk("par_oe0", 32'(parity_err), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
